elastic_config_loader: RTL and testbench



---
 rtl/elastic_config_loader_if.sv | 69 ++++++
 rtl/elastic_config_loader.sv | 198 +++++++++++++++++++
 tb/tb_elastic_config_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_config_loader_if.sv
// Config-load bus between a host/DMA record source and elastic_config_loader.
//
// Carries the load request (load_start, count, max id), the packed record
// stream (record_data / valid_input / stop_input), the broadcast config fields,
// the one-hot per-PE write strobe, and the status/launch outputs.
//
// Modports:
//   master - the loader: consumes requests and records, drives the PE config
//            bus, stop_input and status.
//   slave  - the host side: drives requests and records, observes the rest.
interface elastic_config_loader_if #(
  parameter int unsigned PE_NUM                  = 16,
  parameter int unsigned PE_INDEX_BIT_LENGTH     = 4,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 4,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned NEIGHBOR_PE_NUM         = 4,
  parameter int unsigned OPERATION_BIT_LENGTH    = 5,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned RECORD_COUNT_BIT_LENGTH =
      PE_INDEX_BIT_LENGTH + CONTEXT_SIZE_BIT_LENGTH + 1,
  parameter int unsigned RECORD_WIDTH =
      PE_INDEX_BIT_LENGTH + CONTEXT_SIZE_BIT_LENGTH + 2 * INPUT_NUM_BIT_LENGTH +
      NEIGHBOR_PE_NUM + OPERATION_BIT_LENGTH + DATA_WIDTH
);

  // Load request
  logic                               load_start;
  logic [RECORD_COUNT_BIT_LENGTH-1:0] load_record_count;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id;

  // Record stream
  logic [RECORD_WIDTH-1:0]            record_data;
  logic                               valid_input;
  logic                               stop_input;

  // PE config bus
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2;
  logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index;
  logic [OPERATION_BIT_LENGTH-1:0]    config_op;
  logic [DATA_WIDTH-1:0]              config_const_data;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index;
  logic [PE_NUM-1:0]                  write_config_data;

  // Launch and status
  logic                               start_exec;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;
  logic                               busy;
  logic                               error;

  modport master (
    input  load_start, load_record_count, load_context_max_id,
    input  record_data, valid_input,
    output stop_input,
    output config_input_PE_index_1, config_input_PE_index_2, config_output_PE_index,
    output config_op, config_const_data, config_index, write_config_data,
    output start_exec, mapping_context_max_id, busy, error
  );

  modport slave (
    output load_start, load_record_count, load_context_max_id,
    output record_data, valid_input,
    input  stop_input,
    input  config_input_PE_index_1, config_input_PE_index_2, config_output_PE_index,
    input  config_op, config_const_data, config_index, write_config_data,
    input  start_exec, mapping_context_max_id, busy, error
  );

endinterface

// File: rtl/elastic_config_loader.sv
// Host-side loader for the per-context configuration memories of a PE array.
//
// A load begins with a single-cycle load_start that latches the record count
// and the context max id. Packed records are then taken from a valid/stop
// stream; each accepted record is registered onto the broadcast config_*
// fields together with a one-hot write_config_data strobe for its PE. After
// the last record the strobe gets one FLUSH cycle to land, then start_exec is
// pulsed for one cycle and the loader returns to IDLE.
//
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high
//   bus   - elastic_config_loader_if.master: load request, record stream,
//           PE config bus, start_exec, mapping_context_max_id, busy, error
//
// Record layout, LSB first: const_data, op, output_PE_index, input_PE_index_2,
// input_PE_index_1, config_index, pe_index.
module elastic_config_loader #(
  parameter int unsigned PE_NUM                  = 16,
  parameter int unsigned PE_INDEX_BIT_LENGTH     = 4,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 4,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned NEIGHBOR_PE_NUM         = 4,
  parameter int unsigned OPERATION_BIT_LENGTH    = 5,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned RECORD_COUNT_BIT_LENGTH =
      PE_INDEX_BIT_LENGTH + CONTEXT_SIZE_BIT_LENGTH + 1,
  parameter int unsigned RECORD_WIDTH =
      PE_INDEX_BIT_LENGTH + CONTEXT_SIZE_BIT_LENGTH + 2 * INPUT_NUM_BIT_LENGTH +
      NEIGHBOR_PE_NUM + OPERATION_BIT_LENGTH + DATA_WIDTH
) (
  input logic                     clk,
  input logic                     reset,
  elastic_config_loader_if.master bus
);

  // Field offsets inside a packed record
  localparam int unsigned ConstLsb = 0;
  localparam int unsigned OpLsb    = ConstLsb + DATA_WIDTH;
  localparam int unsigned OutLsb   = OpLsb + OPERATION_BIT_LENGTH;
  localparam int unsigned In2Lsb   = OutLsb + NEIGHBOR_PE_NUM;
  localparam int unsigned In1Lsb   = In2Lsb + INPUT_NUM_BIT_LENGTH;
  localparam int unsigned CtxLsb   = In1Lsb + INPUT_NUM_BIT_LENGTH;
  localparam int unsigned PeLsb    = CtxLsb + CONTEXT_SIZE_BIT_LENGTH;

  localparam logic [RECORD_COUNT_BIT_LENGTH-1:0] CountOne = RECORD_COUNT_BIT_LENGTH'(1);
  localparam logic [PE_NUM-1:0]                  StrobeOne = PE_NUM'(1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StStart
  } state_e;

  state_e state_q, state_d;

  logic [RECORD_COUNT_BIT_LENGTH-1:0] count_q, count_d;
  logic [RECORD_COUNT_BIT_LENGTH-1:0] accepted_q, accepted_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
  logic                               error_q, error_d;

  logic [INPUT_NUM_BIT_LENGTH-1:0]    in1_q, in1_d;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    in2_q, in2_d;
  logic [NEIGHBOR_PE_NUM-1:0]         out_mask_q, out_mask_d;
  logic [OPERATION_BIT_LENGTH-1:0]    op_q, op_d;
  logic [DATA_WIDTH-1:0]              const_q, const_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_q, ctx_d;
  logic [PE_NUM-1:0]                  strobe_q, strobe_d;

  logic stop;
  logic busy;
  logic start_exec;
  logic accept;
  logic pe_in_range;

  logic [PE_INDEX_BIT_LENGTH-1:0] rec_pe;

  assign rec_pe      = bus.record_data[PeLsb +: PE_INDEX_BIT_LENGTH];
  assign pe_in_range = 32'(rec_pe) < PE_NUM;

  // stop_input comes from the state alone so the source never sees a
  // combinational path from valid_input back to stop_input.
  assign accept = bus.valid_input && !stop;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    max_id_d   = max_id_q;
    error_d    = error_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    out_mask_d = out_mask_q;
    op_d       = op_q;
    const_d    = const_q;
    ctx_d      = ctx_q;
    // The strobe is a single-cycle pulse; any cycle without an acceptance clears it.
    strobe_d   = '0;
    stop       = 1'b1;
    busy       = 1'b1;
    start_exec = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (bus.load_start) begin
          count_d    = bus.load_record_count;
          max_id_d   = bus.load_context_max_id;
          error_d    = 1'b0;
          accepted_d = '0;
          state_d    = (bus.load_record_count != '0) ? StLoad : StStart;
        end
      end

      StLoad: begin
        stop = 1'b0;
        if (accept) begin
          in1_d      = bus.record_data[In1Lsb +: INPUT_NUM_BIT_LENGTH];
          in2_d      = bus.record_data[In2Lsb +: INPUT_NUM_BIT_LENGTH];
          out_mask_d = bus.record_data[OutLsb +: NEIGHBOR_PE_NUM];
          op_d       = bus.record_data[OpLsb +: OPERATION_BIT_LENGTH];
          const_d    = bus.record_data[ConstLsb +: DATA_WIDTH];
          // Context indices above the max id are passed through unchanged.
          ctx_d      = bus.record_data[CtxLsb +: CONTEXT_SIZE_BIT_LENGTH];
          // An out-of-range PE index still consumes and counts the record.
          if (pe_in_range) begin
            strobe_d = StrobeOne << rec_pe;
          end else begin
            error_d = 1'b1;
          end
          accepted_d = accepted_q + CountOne;
          if (accepted_d == count_q) begin
            state_d = StFlush;
          end
        end
      end

      // Lets the final strobe reach the PEs before execution starts.
      StFlush: begin
        state_d = StStart;
      end

      StStart: begin
        start_exec = 1'b1;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      accepted_q <= '0;
      max_id_q   <= '0;
      error_q    <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      out_mask_q <= '0;
      op_q       <= '0;
      const_q    <= '0;
      ctx_q      <= '0;
      strobe_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      max_id_q   <= max_id_d;
      error_q    <= error_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      out_mask_q <= out_mask_d;
      op_q       <= op_d;
      const_q    <= const_d;
      ctx_q      <= ctx_d;
      strobe_q   <= strobe_d;
    end
  end

  assign bus.stop_input              = stop;
  assign bus.busy                    = busy;
  assign bus.start_exec              = start_exec;
  assign bus.error                   = error_q;
  assign bus.mapping_context_max_id  = max_id_q;
  assign bus.config_input_PE_index_1 = in1_q;
  assign bus.config_input_PE_index_2 = in2_q;
  assign bus.config_output_PE_index  = out_mask_q;
  assign bus.config_op               = op_q;
  assign bus.config_const_data       = const_q;
  assign bus.config_index            = ctx_q;
  assign bus.write_config_data       = strobe_q;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Randomized self-checking bench for elastic_config_loader. Two instances
// (PE_NUM=16 and PE_NUM=12) share one stimulus stream; a transaction-level
// model predicts every output each cycle.
module tb_elastic_config_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        in_ls = 1'b0;
  logic [8:0]  in_cnt = '0;
  logic [3:0]  in_max = '0;
  logic [54:0] in_rec = '0;
  logic        in_valid = 1'b0;

  elastic_config_loader_if #(.PE_NUM(16)) if16 ();
  elastic_config_loader_if #(.PE_NUM(12)) if12 ();

  assign if16.load_start          = in_ls;
  assign if16.load_record_count   = in_cnt;
  assign if16.load_context_max_id = in_max;
  assign if16.record_data         = in_rec;
  assign if16.valid_input         = in_valid;
  assign if12.load_start          = in_ls;
  assign if12.load_record_count   = in_cnt;
  assign if12.load_context_max_id = in_max;
  assign if12.record_data         = in_rec;
  assign if12.valid_input         = in_valid;

  elastic_config_loader #(.PE_NUM(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  elastic_config_loader #(.PE_NUM(12)) dut12 (.clk(clk), .reset(reset), .bus(if12));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: records still owed, absolute cycle of the start pulse,
  // last written fields, and per-instance strobe/error.
  int          m_remaining;
  int          m_start_cycle;
  logic [3:0]  m_max;
  logic [3:0]  m_ctx;
  logic [2:0]  m_in1, m_in2;
  logic [3:0]  m_out;
  logic [4:0]  m_op;
  logic [31:0] m_const;
  logic [15:0] m_strobe [2];
  logic        m_err [2];
  int          pe_num [2] = '{16, 12};
  string       dname [2] = '{"pe16", "pe12"};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mkrec(input int pe, input int ctx, input int in1, input int in2,
                                        input int outm, input int op, input logic [31:0] c);
    return {4'(pe), 4'(ctx), 3'(in1), 3'(in2), 4'(outm), 5'(op), c};
  endfunction

  function automatic logic [54:0] rand_rec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[54:0];
  endfunction

  task automatic model_reset();
    m_remaining   = 0;
    m_start_cycle = -1;
    m_max = '0; m_ctx = '0; m_in1 = '0; m_in2 = '0; m_out = '0; m_op = '0; m_const = '0;
    for (int i = 0; i < 2; i++) begin
      m_strobe[i] = '0;
      m_err[i]    = 1'b0;
    end
  endtask

  // Advance the model across the coming clock edge using the held inputs.
  task automatic model_update();
    int pe;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) m_strobe[i] = '0;
    if (m_remaining > 0) begin
      if (in_valid) begin
        pe      = int'(in_rec[54:51]);
        m_ctx   = in_rec[50:47];
        m_in1   = in_rec[46:44];
        m_in2   = in_rec[43:41];
        m_out   = in_rec[40:37];
        m_op    = in_rec[36:32];
        m_const = in_rec[31:0];
        for (int i = 0; i < 2; i++) begin
          if (pe < pe_num[i]) m_strobe[i] = 16'd1 << pe;
          else m_err[i] = 1'b1;
        end
        m_remaining--;
        if (m_remaining == 0) m_start_cycle = cyc + 2;
      end
    end else if (m_start_cycle < cyc && in_ls) begin
      m_max = in_max;
      for (int i = 0; i < 2; i++) m_err[i] = 1'b0;
      if (in_cnt != 0) m_remaining = int'(in_cnt);
      else m_start_cycle = cyc + 1;
    end
  endtask

  task automatic cmp_dut(input int i, input logic stop, input logic bsy, input logic st,
                         input logic [15:0] wcd, input logic er, input logic [3:0] mx,
                         input logic [3:0] ci, input logic [2:0] i1, input logic [2:0] i2,
                         input logic [3:0] om, input logic [4:0] op, input logic [31:0] cd,
                         input bit ff);
    string p;
    p = $sformatf("%s c%0d", dname[i], cyc);
    check_eq({p, " stop_input"}, 64'(stop), 64'(m_remaining == 0));
    check_eq({p, " busy"}, 64'(bsy), 64'(m_remaining > 0 || m_start_cycle >= cyc));
    check_eq({p, " start_exec"}, 64'(st), 64'(m_start_cycle == cyc));
    check_eq({p, " write_config_data"}, 64'(wcd), 64'(m_strobe[i]));
    check_eq({p, " error"}, 64'(er), 64'(m_err[i]));
    check_eq({p, " max_id"}, 64'(mx), 64'(m_max));
    if (ff || m_strobe[i] != '0) begin
      check_eq({p, " config_index"}, 64'(ci), 64'(m_ctx));
      check_eq({p, " in1"}, 64'(i1), 64'(m_in1));
      check_eq({p, " in2"}, 64'(i2), 64'(m_in2));
      check_eq({p, " out_mask"}, 64'(om), 64'(m_out));
      check_eq({p, " op"}, 64'(op), 64'(m_op));
      check_eq({p, " const"}, 64'(cd), 64'(m_const));
    end
  endtask

  task automatic compare_all(input bit ff);
    cmp_dut(0, if16.stop_input, if16.busy, if16.start_exec, if16.write_config_data, if16.error,
            if16.mapping_context_max_id, if16.config_index, if16.config_input_PE_index_1,
            if16.config_input_PE_index_2, if16.config_output_PE_index, if16.config_op,
            if16.config_const_data, ff);
    cmp_dut(1, if12.stop_input, if12.busy, if12.start_exec, 16'(if12.write_config_data),
            if12.error, if12.mapping_context_max_id, if12.config_index,
            if12.config_input_PE_index_1, if12.config_input_PE_index_2,
            if12.config_output_PE_index, if12.config_op, if12.config_const_data, ff);
  endtask

  // Check mid-cycle, then move through the next edge; inputs change #1 after it.
  task automatic step();
    @(negedge clk);
    compare_all(1'b0);
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset asserted between edges must clear outputs before any clock edge.
  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all(1'b1);
    step();
    reset = 1'b0;
  endtask

  task automatic send(input logic [54:0] rec);
    in_rec   = rec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_rec   = rand_rec();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_rec = rand_rec();
      step();
    end
  endtask

  task automatic start_load(input int cnt, input int mx);
    in_ls  = 1'b1;
    in_cnt = 9'(cnt);
    in_max = 4'(mx);
    step();
    in_ls  = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    async_reset();
    idle(2);

    // Normal back-to-back load
    start_load(3, 2);
    send(mkrec(0, 0, 1, 2, 4'h3, 3, 32'h11));
    send(mkrec(5, 1, 3, 4, 4'h5, 7, 32'h22));
    send(mkrec(15, 2, 5, 6, 4'ha, 9, 32'h33));
    idle(4);

    // Valid gaps 1,0,0,1,0,1
    start_load(3, 7);
    send(mkrec(2, 9, 1, 1, 1, 1, 32'hdead_beef));
    idle(2);
    send(mkrec(7, 15, 2, 2, 2, 2, 32'h1234_5678));
    idle(1);
    send(mkrec(11, 3, 7, 7, 15, 31, 32'hffff_ffff));
    idle(4);

    // Zero count
    start_load(0, 5);
    idle(3);

    // Out-of-range PE for the 12-PE instance, then error clear by next load
    start_load(2, 1);
    send(mkrec(13, 0, 1, 2, 3, 4, 32'h55));
    send(mkrec(4, 1, 2, 3, 4, 5, 32'h66));
    idle(3);
    start_load(0, 3);
    idle(3);

    // Reset after 1 of 4 records, then a clean single-record load
    start_load(4, 6);
    send(mkrec(1, 1, 1, 1, 1, 1, 32'h77));
    in_valid = 1'b1;
    in_rec   = mkrec(3, 2, 2, 2, 2, 2, 32'h88);
    async_reset();
    in_valid = 1'b0;
    idle(1);
    start_load(1, 4);
    send(mkrec(9, 4, 3, 3, 3, 3, 32'h99));
    idle(4);

    // load_start while busy is ignored
    start_load(3, 5);
    send(mkrec(6, 0, 0, 0, 0, 0, 32'haa));
    in_ls = 1'b1; in_cnt = 9'd1; in_max = 4'd9;
    send(mkrec(8, 1, 1, 1, 1, 1, 32'hbb));
    in_ls = 1'b0;
    send(mkrec(10, 2, 2, 2, 2, 2, 32'hcc));
    idle(4);

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      in_rec   = rand_rec();
      in_valid = ($urandom_range(0, 9) < 7);
      in_ls    = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        in_ls  = 1'b1;
        in_cnt = 9'($urandom_range(0, 6));
        in_max = 4'($urandom);
      end
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end
    in_ls    = 1'b0;
    in_valid = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
